// File: rtl/acc_serial_tx.sv
// acc_serial_tx: unloads the accumulator onto an asynchronous serial line.
// Frame: start(0), DATA_WIDTH data bits LSB-first, optional even parity, stop(1).
// Define ACC_TX_PARITY_EN to insert the even-parity bit after the data bits.
module acc_serial_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  reg_clk,
  input  logic                  reg_rst_n,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic                  rd_req,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  ser_out
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef ACC_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cyc_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  bit_end;
  logic                  last_bit;
  logic                  accept;
`ifdef ACC_TX_PARITY_EN
  logic                  par;
`endif

  assign bit_end  = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign accept   = (state == IDLE) && rd_req;

  // State register, counters, shift register and done pulse
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      rd_done <= 1'b0;
`ifdef ACC_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rd_done <= (state == STOP) && bit_end;

      if (state == IDLE || bit_end)
        cyc_cnt <= '0;
      else
        cyc_cnt <= cyc_cnt + CW'(1);

      if (state != DATA)
        bit_cnt <= '0;
      else if (bit_end)
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);

      if (accept)
        shreg <= acc_in;
      else if (state == DATA && bit_end)
        shreg <= shreg >> 1;

`ifdef ACC_TX_PARITY_EN
      // Parity is taken at capture since the data is shifted out afterwards
      if (accept)
        par <= ^acc_in;
`endif
    end
  end

  // Next-state: each non-idle state is held for BIT_CYCLES clocks
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (rd_req) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
`ifdef ACC_TX_PARITY_EN
      DATA:   if (bit_end && last_bit) state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
`else
      DATA:   if (bit_end && last_bit) state_nxt = STOP;
`endif
      STOP:   if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state so reset forces the idle line at once
  always_comb begin
    ser_out = 1'b1;
    rd_busy = (state != IDLE);
    unique case (state)
      IDLE:   ser_out = 1'b1;
      START:  ser_out = 1'b0;
      DATA:   ser_out = shreg[0];
`ifdef ACC_TX_PARITY_EN
      PARITY: ser_out = par;
`endif
      STOP:   ser_out = 1'b1;
      default: ser_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_acc_serial_tx.sv
// tb_acc_serial_tx: directed scoreboard bench for acc_serial_tx (BIT_CYCLES=2).
// Honors ACC_TX_PARITY_EN the same way as the design.
module tb_acc_serial_tx;

  localparam int DW = 8;
  localparam int BC = 2;
`ifdef ACC_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] acc = '0;
  logic          req = 1'b0;
  logic          busy, done, ser;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  acc_serial_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
    .reg_clk  (clk),
    .reg_rst_n(rst_n),
    .acc_in   (acc),
    .rd_req   (req),
    .rd_busy  (busy),
    .rd_done  (done),
    .ser_out  (ser)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame of data d
  task automatic push_frame(input logic [DW-1:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef ACC_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge; returns just after the rd_done edge.
  // At cycle index poke, rd_req is pulsed and acc_in overwritten with FF.
  task automatic check_frame(input string tag, input int poke);
    for (int b = 0; b < NB; b++) begin
      logic e;
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 8'd0, 8'd1);
        e = 1'b1;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < BC; c++) begin
        chk({tag, "_ser"}, {7'd0, ser}, {7'd0, e});
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
        chk({tag, "_done_early"}, {7'd0, done}, 8'd0);
        if (b * BC + c == poke) begin
          req = 1'b1;
          acc = 8'hFF;
        end
        tick();
        if (b * BC + c == poke) req = 1'b0;
      end
    end
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_busy_end"}, {7'd0, busy}, 8'd0);
    chk({tag, "_ser_end"}, {7'd0, ser}, 8'd1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    acc = d;
    req = 1'b1;
    tick();
    req = 1'b0;
    push_frame(d);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ser", {7'd0, ser}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ser", {7'd0, ser}, 8'd1);

    // Single frame A5, done pulses exactly one cycle
    send(8'hA5);
    check_frame("t1", -1);
    tick();
    chk("t1_done_pulse", {7'd0, done}, 8'd0);
    chk("t1_idle_ser", {7'd0, ser}, 8'd1);
    chk("t1_idle_busy", {7'd0, busy}, 8'd0);

    // Frame 07 (parity 1 when enabled)
    send(8'h07);
    check_frame("t2", -1);
    tick();
    chk("t2_done_pulse", {7'd0, done}, 8'd0);

    // Back-to-back: rd_req held, second frame starts right after rd_done
    acc = 8'h3C;
    req = 1'b1;
    tick();
    push_frame(8'h3C);
    acc = 8'hC3;
    check_frame("t3a", -1);
    tick();
    req = 1'b0;
    push_frame(8'hC3);
    check_frame("t3b", -1);
    tick();
    chk("t3_done_pulse", {7'd0, done}, 8'd0);

    // Request and data change mid-frame are ignored
    send(8'h5A);
    check_frame("t4", 7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_extra", {7'd0, busy}, 8'd0);
    end

    // Reset during data bit 4 aborts the frame
    send(8'hA5);
    exp_q.delete();
    repeat (10) tick();
    chk("t5_bit4", {7'd0, ser}, 8'd0);
    chk("t5_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ser", {7'd0, ser}, 8'd1);
    chk("t5_async_busy", {7'd0, busy}, 8'd0);
    chk("t5_async_done", {7'd0, done}, 8'd0);
    tick();
    tick();
    chk("t5_rst_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_post_busy", {7'd0, busy}, 8'd0);
    chk("t5_post_done", {7'd0, done}, 8'd0);
    send(8'h96);
    check_frame("t5_clean", -1);
    tick();
    chk("t5_done_pulse", {7'd0, done}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
